avr_fmul_seq: RTL and testbench

- Parametrised, multi-cycle successor to the combinational AVR fractional-multiply model.
- One iterative shift-add datapath executes all four AVR multiply flavours, selected per transaction by a mode input: MUL, FMUL, FMULS and FMULSU.
- Operands come in through a valid/ready handshake. Result high/low words plus C and Z flags go out through a second valid/ready handshake.
- Sits between the register-file read stage and writeback (r1:r0 and SREG).

---
 rtl/avr_fmul_seq.sv | 197 +++++++++++++++++++
 tb/tb_avr_fmul_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/avr_fmul_seq.sv
// avr_fmul_seq: multi-cycle AVR multiply unit (MUL / FMUL / FMULS / FMULSU).
// It uses one shift-add datapath that processes one multiplier bit per clock.
// Operands are accepted through a valid/ready handshake. The result {r1,r0}
// and the C and Z flags are returned through a second valid/ready handshake.
// Optional feature macro: AVR_FMUL_SAT_EN. When it is defined, FMULS of
// (most-negative * most-negative) saturates to 0111..1 instead of wrapping.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | o_ready=1, waiting for i_valid to capture operands and mode
// MUL    | one shift-add per edge; the terminal-count edge finalises
// DONE   | o_valid=1, result held until i_ready
module avr_fmul_seq #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_rd,
  input  logic [WIDTH-1:0] i_rr,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_r1,
  output logic [WIDTH-1:0] o_r0,
  output logic             o_c,
  output logic             o_z
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] MODE_MUL    = 2'b00;
  localparam logic [1:0] MODE_FMULS  = 2'b10;
  localparam logic [1:0] MODE_FMULSU = 2'b11;

  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [PW-1:0]    ONE_P = PW'(1);
  localparam logic [CW-1:0]    ONE_C = CW'(1);
  localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] r1_q, r1_d;
  logic [WIDTH-1:0] r0_q, r0_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
`ifdef AVR_FMUL_SAT_EN
  logic             both_min_q, both_min_d;
`endif

  logic             rd_neg, rr_neg;
  logic [WIDTH-1:0] rd_mag, rr_mag;
  logic [PW-1:0]    prod, res;

  // State and datapath registers; asynchronous reset clears everything
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= MODE_MUL;
      mcand_q    <= '0;
      mplier_q   <= '0;
      neg_q      <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      r1_q       <= '0;
      r0_q       <= '0;
      c_q        <= 1'b0;
      z_q        <= 1'b0;
`ifdef AVR_FMUL_SAT_EN
      both_min_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      neg_q      <= neg_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      r1_q       <= r1_d;
      r0_q       <= r0_d;
      c_q        <= c_d;
      z_q        <= z_d;
`ifdef AVR_FMUL_SAT_EN
      both_min_q <= both_min_d;
`endif
    end
  end

  // Next-state logic: accept, iterate until the counter reaches zero, then wait for i_ready
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (i_valid) state_d = S_MUL;
      S_MUL:   if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  if (i_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: operand magnitudes at accept, shift-add per bit, sign/shift/flags at terminal count
  always_comb begin
    mode_d   = mode_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    r1_d     = r1_q;
    r0_d     = r0_q;
    c_d      = c_q;
    z_d      = z_q;
`ifdef AVR_FMUL_SAT_EN
    both_min_d = both_min_q;
`endif

    // Rd is signed in FMULS and FMULSU; Rr is signed only in FMULS
    rd_neg = i_mode[1] & i_rd[WIDTH-1];
    rr_neg = (i_mode == MODE_FMULS) & i_rr[WIDTH-1];
    rd_mag = rd_neg ? (~i_rd + ONE_W) : i_rd;
    rr_mag = rr_neg ? (~i_rr + ONE_W) : i_rr;

    prod = neg_q ? (~acc_q + ONE_P) : acc_q;
    res  = (mode_q == MODE_MUL) ? prod : {prod[PW-2:0], 1'b0};
`ifdef AVR_FMUL_SAT_EN
    if ((mode_q == MODE_FMULS) && both_min_q) res = {1'b0, {(PW-1){1'b1}}};
`endif

    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          mode_d   = i_mode;
          mcand_d  = {{WIDTH{1'b0}}, rd_mag};
          mplier_d = rr_mag;
          neg_d    = rd_neg ^ rr_neg;
          acc_d    = '0;
          cnt_d    = CNT_INIT;
`ifdef AVR_FMUL_SAT_EN
          both_min_d = (i_rd == {1'b1, {(WIDTH-1){1'b0}}}) &&
                       (i_rr == {1'b1, {(WIDTH-1){1'b0}}});
`endif
        end
      end
      S_MUL: begin
        if (cnt_q != '0) begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - ONE_C;
        end else begin
          // C comes from the raw product, before any fractional shift or saturation
          c_d     = prod[PW-1];
          r1_d    = res[PW-1:WIDTH];
          r0_d    = res[WIDTH-1:0];
          z_d     = (res == '0);
          valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (i_ready) valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Output decode: o_ready comes from the state; the result and flags come from holding registers
  always_comb begin
    o_ready = (state_q == S_IDLE);
    o_valid = valid_q;
    o_r1    = r1_q;
    o_r0    = r0_q;
    o_c     = c_q;
    o_z     = z_q;
  end

  // FMULSU is decoded through i_mode[1] above; the name documents the encoding
  logic unused_mode_ok;
  assign unused_mode_ok = (MODE_FMULSU == 2'b11);

endmodule

// File: tb/tb_avr_fmul_seq.sv
// Directed testbench for avr_fmul_seq with WIDTH=8. Expected values are computed by hand.
module tb_avr_fmul_seq;

  logic       clk;
  logic       rst_n;
  logic       i_valid;
  logic       o_ready;
  logic [1:0] i_mode;
  logic [7:0] i_rd;
  logic [7:0] i_rr;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_r1;
  logic [7:0] o_r0;
  logic       o_c;
  logic       o_z;

  int n_checks = 0;
  int n_errors = 0;

  avr_fmul_seq #(.WIDTH(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_mode  (i_mode),
    .i_rd    (i_rd),
    .i_rr    (i_rr),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_r1    (o_r1),
    .o_r0    (o_r0),
    .o_c     (o_c),
    .o_z     (o_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op and wait for o_valid. lat counts the edges after the accepting edge.
  task automatic issue(input logic [1:0] mode, input logic [7:0] rd, input logic [7:0] rr,
                       output int lat);
    @(negedge clk);
    check("ready_before_accept", {31'd0, o_ready}, 32'd1);
    i_valid = 1'b1; i_mode = mode; i_rd = rd; i_rr = rr;
    @(posedge clk); #1;
    i_valid = 1'b0; i_rd = 8'h5A; i_rr = 8'hA5; i_mode = 2'b01;
    lat = 0;
    while (!o_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_op;
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk); #1;
    check("valid_drop", {31'd0, o_valid}, 32'd0);
    check("ready_back", {31'd0, o_ready}, 32'd1);
    i_ready = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic [1:0] mode, input logic [7:0] rd,
                         input logic [7:0] rr, input logic [15:0] exp_r,
                         input logic exp_c, input logic exp_z);
    int lat;
    issue(mode, rd, rr, lat);
    check({tag, "_lat"}, lat, 32'd9);
    check({tag, "_r"}, {16'd0, o_r1, o_r0}, {16'd0, exp_r});
    check({tag, "_c"}, {31'd0, o_c}, {31'd0, exp_c});
    check({tag, "_z"}, {31'd0, o_z}, {31'd0, exp_z});
    finish_op();
  endtask

  initial begin
    logic [15:0] r_hold;
    logic        c_hold, z_hold;
    int          lat;
    logic [15:0] sat_exp;

    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_mode = 2'b00; i_rd = 8'h00; i_rr = 8'h00;
    #12;
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_r", {16'd0, o_r1, o_r0}, 32'd0);
    check("rst_cz", {30'd0, o_c, o_z}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // FMULSU -64 * 128 = -8192 = 0xE000, shifted left to 0xC000
    run_vec("fmulsu", 2'b11, 8'hC0, 8'h80, 16'hC000, 1'b1, 1'b0);
    run_vec("mul_ff", 2'b00, 8'hFF, 8'hFF, 16'hFE01, 1'b1, 1'b0);
    run_vec("fmul_80", 2'b01, 8'h80, 8'h80, 16'h8000, 1'b0, 1'b0);
`ifdef AVR_FMUL_SAT_EN
    sat_exp = 16'h7FFF;
`else
    sat_exp = 16'h8000;
`endif
    run_vec("fmuls_min", 2'b10, 8'h80, 8'h80, sat_exp, 1'b0, 1'b0);
    run_vec("fmuls_zero", 2'b10, 8'h00, 8'h93, 16'h0000, 1'b0, 1'b1);
    run_vec("fmuls_m1", 2'b10, 8'hFF, 8'h01, 16'hFFFE, 1'b1, 1'b0);
    // FMULS 0x93(-109) * 0x05 = -545 = 0xFDDF, shifted left to 0xFBBE
    run_vec("fmuls_neg", 2'b10, 8'h93, 8'h05, 16'hFBBE, 1'b1, 1'b0);
    // FMULSU 0x7F(127) * 0xFF(255) = 32385 = 0x7E81, shifted left to 0xFD02
    run_vec("fmulsu_pos", 2'b11, 8'h7F, 8'hFF, 16'hFD02, 1'b0, 1'b0);

    // Backpressure: MUL 0x12*0x34 = 0x03A8
    issue(2'b00, 8'h12, 8'h34, lat);
    check("bp_lat", lat, 32'd9);
    check("bp_r", {16'd0, o_r1, o_r0}, 32'h03A8);
    r_hold = {o_r1, o_r0}; c_hold = o_c; z_hold = o_z;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      i_valid = ~i_valid; i_rd = 8'(k * 37); i_rr = 8'(k * 11 + 3); i_mode = 2'(k);
      @(posedge clk); #1;
      check("bp_valid", {31'd0, o_valid}, 32'd1);
      check("bp_ready", {31'd0, o_ready}, 32'd0);
      check("bp_hold", {14'd0, o_r1, o_r0, o_c, o_z}, {14'd0, r_hold, c_hold, z_hold});
    end
    @(negedge clk);
    i_valid = 1'b0; i_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rel_ready", {31'd0, o_ready}, 32'd1);
    check("bp_rel_valid", {31'd0, o_valid}, 32'd0);
    check("bp_rel_keep", {16'd0, o_r1, o_r0}, 32'h03A8);
    i_ready = 1'b0;

    // Asynchronous reset on the 4th MUL edge
    @(negedge clk);
    i_valid = 1'b1; i_mode = 2'b00; i_rd = 8'h77; i_rr = 8'h66;
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("mid_ready", {31'd0, o_ready}, 32'd0);
    for (int k = 0; k < 4; k++) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_ready", {31'd0, o_ready}, 32'd1);
    check("arst_valid", {31'd0, o_valid}, 32'd0);
    check("arst_r", {16'd0, o_r1, o_r0}, 32'd0);
    check("arst_cz", {30'd0, o_c, o_z}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_vec("mul_3x5", 2'b00, 8'h03, 8'h05, 16'h000F, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout: got no completion expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
